// File: rtl/clock_hand_timer.sv
//==============================================================================
// Module   : clock_hand_timer
// Brief    : 12-hour wall-time keeper that converts live time into analog
//            hand angles (0..59) for the VGA clock overlay. The angles are
//            re-latched only on a vertical-sync assertion edge, which is
//            synchronised into the clock_50_MHz domain.
// Options  : define CLOCK_HAND_TIME_SET_EN to enable the inc_min / inc_hour
//            time-set inputs (both together clear the time to 0:00:00).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module clock_hand_timer #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter bit VS_ACTIVE_LOW = 1'b1
) (
  input  logic       clock_50_MHz,
  input  logic       reset_n,
  input  logic       vga_vs,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [5:0] sec_angle,
  output logic [5:0] min_angle,
  output logic [5:0] hour_angle,
  output logic       frame_update,
  output logic       sec_tick
);

  localparam int              c_PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(TICKS_PER_SEC - 1);
  localparam logic            c_VS_IDLE   = VS_ACTIVE_LOW;

  // Live time registers
  logic [c_PW-1:0] r_presc;
  logic [5:0]      r_sec;
  logic [5:0]      r_min;
  logic [3:0]      r_hour;
  logic            r_sec_tick;

  // Vsync synchroniser, edge-detect flop and post-reset fill counter
  logic       r_vs_s1;
  logic       r_vs_s2;
  logic       r_vs_s3;
  logic [1:0] r_fill;

  // Latched (frame-stable) outputs
  logic [5:0] r_sec_angle;
  logic [5:0] r_min_angle;
  logic [5:0] r_hour_angle;
  logic       r_frame_update;

  // Plain prescaler / carry-chain next state
  logic            w_tick;
  logic            w_sec_wrap;
  logic            w_min_wrap;
  logic [c_PW-1:0] w_presc_nx;
  logic [5:0]      w_sec_nx;
  logic [5:0]      w_min_nx;
  logic [3:0]      w_hour_nx;

  // Final next state after time-set adjustments
  logic [c_PW-1:0] w_presc_d;
  logic [5:0]      w_sec_d;
  logic [5:0]      w_min_d;
  logic [3:0]      w_hour_d;
  logic            w_tick_d;

  logic [7:0] w_hour_angle_full;
  logic [5:0] w_hour_angle;
  logic       w_vs_assert;

  assign w_tick     = (r_presc == c_PRESC_MAX);
  assign w_sec_wrap = w_tick && (r_sec == 6'd59);
  assign w_min_wrap = w_sec_wrap && (r_min == 6'd59);

  assign w_presc_nx = w_tick ? '0 : (r_presc + c_PW'(1));
  assign w_sec_nx   = w_tick ? (w_sec_wrap ? 6'd0 : (r_sec + 6'd1)) : r_sec;
  assign w_min_nx   = w_sec_wrap ? ((r_min == 6'd59) ? 6'd0 : (r_min + 6'd1)) : r_min;
  assign w_hour_nx  = w_min_wrap ? ((r_hour == 4'd11) ? 4'd0 : (r_hour + 4'd1)) : r_hour;

`ifdef CLOCK_HAND_TIME_SET_EN
  logic [5:0] w_min_inc;
  logic [3:0] w_hour_inc;

  assign w_min_inc  = (r_min == 6'd59) ? 6'd0 : (r_min + 6'd1);
  assign w_hour_inc = (r_hour == 4'd11) ? 4'd0 : (r_hour + 4'd1);

  // Time-set overrides: inc_min restarts the minute and swallows any tick,
  // inc_hour replaces whatever hour the carry chain produced.
  always_comb begin
    w_presc_d = w_presc_nx;
    w_sec_d   = w_sec_nx;
    w_min_d   = w_min_nx;
    w_hour_d  = w_hour_nx;
    w_tick_d  = w_tick;
    if (inc_min && inc_hour) begin
      w_presc_d = '0;
      w_sec_d   = 6'd0;
      w_min_d   = 6'd0;
      w_hour_d  = 4'd0;
      w_tick_d  = 1'b0;
    end else begin
      if (inc_min) begin
        w_presc_d = '0;
        w_sec_d   = 6'd0;
        w_min_d   = w_min_inc;
        w_hour_d  = r_hour;
        w_tick_d  = 1'b0;
      end
      if (inc_hour) begin
        w_hour_d = w_hour_inc;
      end
    end
  end
`else
  // Time-set inputs exist on the port list but drive nothing in this build.
  logic w_unused_inc;
  assign w_unused_inc = inc_min ^ inc_hour;

  // Time advances from the prescaler alone.
  always_comb begin
    w_presc_d = w_presc_nx;
    w_sec_d   = w_sec_nx;
    w_min_d   = w_min_nx;
    w_hour_d  = w_hour_nx;
    w_tick_d  = w_tick;
  end
`endif

  // Hour hand moves 5 steps per hour plus one step every 12 minutes.
  assign w_hour_angle_full = ({4'd0, r_hour} * 8'd5) + ({2'd0, r_min} / 8'd12);
  assign w_hour_angle      = w_hour_angle_full[5:0];

  // An edge is only trusted once the whole sync chain holds real samples, so
  // a release during an active pulse does not look like a fresh assertion.
  assign w_vs_assert = (r_fill == 2'd3) && (r_vs_s3 == c_VS_IDLE) && (r_vs_s2 != c_VS_IDLE);

  // Live time counters and the registered seconds tick.
  always_ff @(posedge clock_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_presc    <= '0;
      r_sec      <= 6'd0;
      r_min      <= 6'd0;
      r_hour     <= 4'd0;
      r_sec_tick <= 1'b0;
    end else begin
      r_presc    <= w_presc_d;
      r_sec      <= w_sec_d;
      r_min      <= w_min_d;
      r_hour     <= w_hour_d;
      r_sec_tick <= w_tick_d;
    end
  end

  // Bring vsync into this domain and track how many real samples are held.
  always_ff @(posedge clock_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_s1 <= c_VS_IDLE;
      r_vs_s2 <= c_VS_IDLE;
      r_vs_s3 <= c_VS_IDLE;
      r_fill  <= 2'd0;
    end else begin
      r_vs_s1 <= vga_vs;
      r_vs_s2 <= r_vs_s1;
      r_vs_s3 <= r_vs_s2;
      r_fill  <= (r_fill == 2'd3) ? 2'd3 : (r_fill + 2'd1);
    end
  end

  // Capture the current live time into the hand outputs on a sync assertion.
  always_ff @(posedge clock_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_sec_angle    <= 6'd0;
      r_min_angle    <= 6'd0;
      r_hour_angle   <= 6'd0;
      r_frame_update <= 1'b0;
    end else begin
      r_frame_update <= w_vs_assert;
      if (w_vs_assert) begin
        r_sec_angle  <= r_sec;
        r_min_angle  <= r_min;
        r_hour_angle <= w_hour_angle;
      end
    end
  end

  assign sec_angle    = r_sec_angle;
  assign min_angle    = r_min_angle;
  assign hour_angle   = r_hour_angle;
  assign frame_update = r_frame_update;
  assign sec_tick     = r_sec_tick;

endmodule

`default_nettype wire

// File: tb/tb_clock_hand_timer.sv
//==============================================================================
// Module   : tb_clock_hand_timer
// Brief    : Self-checking bench for clock_hand_timer. Time is modelled as a
//            count of seconds into the 12-hour dial; vsync is modelled by its
//            sampled history.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_clock_hand_timer;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       vga_vs = 1'b1;
  logic       inc_min = 1'b0;
  logic       inc_hour = 1'b0;
  logic [5:0] sec_angle;
  logic [5:0] min_angle;
  logic [5:0] hour_angle;
  logic       frame_update;
  logic       sec_tick;

  int total = 0;
  int bad = 0;

  // Reference model state
  int m_pre;
  int m_t;
  int hist[3];
  int exp_sec, exp_min, exp_hour, exp_fu, exp_tick;
  int tick_cnt, fu_cnt;

  clock_hand_timer #(
    .TICKS_PER_SEC(TPS),
    .VS_ACTIVE_LOW(1'b1)
  ) dut (
    .clock_50_MHz(clk),
    .reset_n     (reset_n),
    .vga_vs      (vga_vs),
    .inc_min     (inc_min),
    .inc_hour    (inc_hour),
    .sec_angle   (sec_angle),
    .min_angle   (min_angle),
    .hour_angle  (hour_angle),
    .frame_update(frame_update),
    .sec_tick    (sec_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_t = 0;
    hist[0] = 2; hist[1] = 2; hist[2] = 2;
    exp_sec = 0; exp_min = 0; exp_hour = 0; exp_fu = 0; exp_tick = 0;
  endtask

  // One clock edge of the wall clock: sync history decides a latch of the
  // time as it stood before this edge, then the time itself moves on.
  task automatic model_step();
    int h, mn, nt;
    bit tick;
    if (hist[1] == 0 && hist[2] == 1) begin
      h = m_t / 3600;
      mn = (m_t / 60) % 60;
      exp_sec = m_t % 60;
      exp_min = mn;
      exp_hour = h * 5 + mn / 12;
      exp_fu = 1;
    end else begin
      exp_fu = 0;
    end
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = int'(vga_vs);
    tick = (m_pre == TPS - 1);
    exp_tick = int'(tick);
    h = m_t / 3600;
    mn = (m_t / 60) % 60;
`ifdef CLOCK_HAND_TIME_SET_EN
    if (inc_min && inc_hour) begin
      m_t = 0; m_pre = 0; exp_tick = 0;
    end else if (inc_min) begin
      m_t = h * 3600 + ((mn + 1) % 60) * 60; m_pre = 0; exp_tick = 0;
    end else if (inc_hour) begin
      nt = tick ? (m_t + 1) % 43200 : m_t;
      m_t = ((h + 1) % 12) * 3600 + nt % 3600;
      m_pre = (m_pre + 1) % TPS;
    end else begin
      if (tick) m_t = (m_t + 1) % 43200;
      m_pre = (m_pre + 1) % TPS;
    end
`else
    nt = 0;
    if (tick) m_t = (m_t + 1) % 43200;
    m_pre = (m_pre + 1) % TPS;
`endif
  endtask

  task automatic check_all();
    chk("sec_angle", sec_angle, exp_sec[7:0]);
    chk("min_angle", min_angle, exp_min[7:0]);
    chk("hour_angle", hour_angle, exp_hour[7:0]);
    chk("frame_update", frame_update, exp_fu[7:0]);
    chk("sec_tick", sec_tick, exp_tick[7:0]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (sec_tick) tick_cnt++;
    if (frame_update) fu_cnt++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;
  endtask

  task automatic pulse_set(input bit m, input bit h);
    inc_min = m; inc_hour = h;
    cyc();
    inc_min = 1'b0; inc_hour = 1'b0;
  endtask

  initial begin
    int hold;
    @(posedge clk);
    #1;

    // Reset state, then 40 idle cycles with vsync held idle.
    vga_vs = 1'b1;
    do_reset();
    tick_cnt = 0; fu_cnt = 0;
    for (int i = 0; i < 40; i++) cyc();
    chk("tick_count_40", tick_cnt[7:0], 8'd10);
    chk("fu_count_idle", fu_cnt[7:0], 8'd0);

    // Run to 0:36:00 on ticks alone, then a sync assertion and a deassertion.
    do_reset();
    for (int i = 0; i < 36 * 60 * TPS; i++) cyc();
    vga_vs = 1'b0;
    cyc(); cyc();
    chk("fu_before_latency", frame_update, 8'd0);
    cyc();
    chk("fu_at_latency", frame_update, 8'd1);
    chk("min_0036", min_angle, 8'd36);
    chk("hour_0036", hour_angle, 8'd3);
    for (int i = 0; i < 5; i++) cyc();
    fu_cnt = 0;
    vga_vs = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    chk("rise_no_update", fu_cnt[7:0], 8'd0);
    chk("min_hold", min_angle, 8'd36);

`ifdef CLOCK_HAND_TIME_SET_EN
    // Preload 11:59:59, one tick wraps to 0:00:00, then latch it.
    do_reset();
    for (int i = 0; i < 4; i++) cyc();
    for (int i = 0; i < 11; i++) pulse_set(1'b0, 1'b1);
    for (int i = 0; i < 59; i++) pulse_set(1'b1, 1'b0);
    for (int i = 0; i < 59 * TPS; i++) cyc();
    for (int i = 0; i < TPS; i++) cyc();
    vga_vs = 1'b0;
    cyc(); cyc(); cyc();
    chk("wrap_fu", frame_update, 8'd1);
    chk("wrap_sec", sec_angle, 8'd0);
    chk("wrap_min", min_angle, 8'd0);
    chk("wrap_hour", hour_angle, 8'd0);
    cyc();
    chk("wrap_fu_once", frame_update, 8'd0);
    vga_vs = 1'b1;
    for (int i = 0; i < 4; i++) cyc();

    // 3:36:00 via sets.
    do_reset();
    for (int i = 0; i < 4; i++) cyc();
    for (int i = 0; i < 3; i++) pulse_set(1'b0, 1'b1);
    for (int i = 0; i < 36; i++) pulse_set(1'b1, 1'b0);
    vga_vs = 1'b0;
    cyc(); cyc(); cyc();
    chk("hour_0336", hour_angle, 8'd18);
    chk("min_0336", min_angle, 8'd36);
    vga_vs = 1'b1;
    for (int i = 0; i < 4; i++) cyc();

    // inc_min on the terminal prescaler count swallows the tick.
    do_reset();
    for (int i = 0; i < TPS - 1; i++) cyc();
    pulse_set(1'b1, 1'b0);
    chk("set_no_tick", sec_tick, 8'd0);
    vga_vs = 1'b0;
    cyc(); cyc(); cyc();
    chk("set_sec", sec_angle, 8'd0);
    chk("set_min", min_angle, 8'd1);
    vga_vs = 1'b1;
    pulse_set(1'b0, 1'b1);
    pulse_set(1'b1, 1'b1);
    vga_vs = 1'b0;
    cyc(); cyc(); cyc();
    chk("both_sec", sec_angle, 8'd0);
    chk("both_min", min_angle, 8'd0);
    chk("both_hour", hour_angle, 8'd0);
    vga_vs = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
`endif

    // Randomised vsync and time-set pulses against the model.
    hold = 0;
    for (int i = 0; i < 800; i++) begin
      if (hold == 0) begin
        vga_vs = ~vga_vs;
        hold = int'($urandom_range(1, 8));
      end
      hold--;
      inc_min  = ($urandom_range(0, 7) == 0);
      inc_hour = ($urandom_range(0, 7) == 0);
      cyc();
    end
    inc_min = 1'b0; inc_hour = 1'b0;

    // Reset during an active pulse, released while still active.
    vga_vs = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    do_reset();
    fu_cnt = 0;
    for (int i = 0; i < 10; i++) cyc();
    chk("midpulse_no_fu", fu_cnt[7:0], 8'd0);
    chk("midpulse_sec", sec_angle, 8'd0);
    vga_vs = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    vga_vs = 1'b0;
    cyc(); cyc(); cyc();
    chk("midpulse_next_fu", frame_update, 8'd1);
    for (int i = 0; i < 4; i++) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
